// File: rtl/sasa_wb_pkg.sv
// Shared types and widths for the SASA result write-back stage.
//   wb_state_t : write-back FSM states
//   DataW      : result word width
//   CountW     : width of the accepted-write counter
package sasa_wb_pkg;

    localparam int unsigned DataW  = 32;
    localparam int unsigned CountW = 16;

    typedef enum logic [1:0] {
        StIdle,
        StCollect,
        StDrain,
        StDone
    } wb_state_t;

endpackage

// File: rtl/sasa_wb_fifo.sv
// Synchronous circular capture FIFO with show-ahead read data.
// Ports:
//   clk_i, rst_ni      : clock, synchronous active-low reset
//   push_i / data_i    : write strobe and word (ignored when full)
//   pop_i  / data_o    : read strobe and head word (ignored when empty)
//   full_o, empty_o    : occupancy status
module sasa_wb_fifo #(
    parameter int unsigned Depth = 8,
    parameter int unsigned Width = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [Width-1:0] data_i,
    output logic [Width-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    // One extra pointer bit separates full from empty.
    localparam int unsigned PtrW = $clog2(Depth) + 1;

    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [Width-1:0] mem_q [Depth];

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[PtrW-1] != rd_ptr_q[PtrW-1]) &&
                     (wr_ptr_q[PtrW-2:0] == rd_ptr_q[PtrW-2:0]);
    assign data_o  = mem_q[rd_ptr_q[PtrW-2:0]];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_i && !full_o) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_i && !empty_o) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i && !full_o) begin
            mem_q[wr_ptr_q[PtrW-2:0]] <= data_i;
        end
    end

endmodule

// File: rtl/sasa_result_writer.sv
// Write-back stage for the SASA softmax engine: captures Result words while
// soft_fac is high, buffers them, and drains them to a valid/ready write port
// with row/column address generation.
// Ports:
//   clk, reset (sync, active-low)
//   soft_fac, Result, finish      : SASA result stream
//   wr_valid, wr_ready, wr_addr, wr_data : write port
//   wb_busy, wb_done              : FSM status
//   overflow, clamp_flag          : sticky flags
//   wb_count                      : saturating count of accepted writes
// Optional feature macro: SASA_WB_CLAMP_EN (negative words stored as zero).
module sasa_result_writer
    import sasa_wb_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned SEG_LEN    = 4,
    parameter int unsigned ROW_STRIDE = 16,
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned BASE_ADDR  = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              soft_fac,
    input  logic [DataW-1:0]  Result,
    input  logic              finish,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DataW-1:0]  wr_data,
    output logic              wb_busy,
    output logic              wb_done,
    output logic              overflow,
    output logic              clamp_flag,
    output logic [CountW-1:0] wb_count
);

    wb_state_t         state_q, state_d;
    logic [ADDR_W-1:0] row_q, row_d, col_q, col_d, addr_q, addr_d;
    logic [DataW-1:0]  data_q, data_d, push_data, fifo_rdata;
    logic [CountW-1:0] cnt_q, cnt_d;
    logic              valid_q, valid_d, ovf_q, ovf_d, clamp_q, clamp_d;
    logic              fifo_full, fifo_empty, push, pop, accept, active;
    logic              enter_collect, clamp_hit;

    assign active        = (state_q == StCollect) || (state_q == StDrain);
    assign accept        = valid_q && wr_ready;
    assign push          = soft_fac && !fifo_full;
    // Load the output register when it is free or being emptied this cycle.
    assign pop           = active && !fifo_empty && (!valid_q || accept);
    assign enter_collect = soft_fac && ((state_q == StIdle) || (state_q == StDone));

`ifdef SASA_WB_CLAMP_EN
    assign clamp_hit = push && Result[DataW-1];
    assign push_data = Result[DataW-1] ? '0 : Result;
`else
    assign clamp_hit = 1'b0;
    assign push_data = Result;
`endif

    sasa_wb_fifo #(
        .Depth (FIFO_DEPTH),
        .Width (DataW)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (reset),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (push_data),
        .data_o  (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        addr_d  = addr_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        ovf_d   = ovf_q;
        clamp_d = clamp_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (soft_fac) state_d = StCollect;
            end
            StCollect: begin
                if (finish || !soft_fac) state_d = StDrain;
            end
            StDrain: begin
                // A same-cycle push would leave a word behind, so wait for it.
                if (fifo_empty && !push && (!valid_q || accept)) state_d = StDone;
            end
            default: state_d = StIdle;
        endcase

        if (enter_collect) begin
            row_d   = '0;
            col_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
            clamp_d = 1'b0;
        end
        if (soft_fac && fifo_full) ovf_d = 1'b1;
        if (clamp_hit) clamp_d = 1'b1;

        if (accept) begin
            valid_d = 1'b0;
            if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
        end

        if (pop) begin
            valid_d = 1'b1;
            data_d  = fifo_rdata;
            addr_d  = ADDR_W'(BASE_ADDR) + row_q * ADDR_W'(ROW_STRIDE) + col_q;
            if (col_q == ADDR_W'(SEG_LEN - 1)) begin
                col_d = '0;
                row_d = row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
            row_q   <= '0;
            col_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            clamp_q <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            clamp_q <= clamp_d;
        end
    end

    assign wr_valid   = valid_q;
    assign wr_addr    = addr_q;
    assign wr_data    = data_q;
    assign wb_busy    = active;
    assign wb_done    = (state_q == StDone);
    assign overflow   = ovf_q;
    assign clamp_flag = clamp_q;
    assign wb_count   = cnt_q;

endmodule

// File: tb/tb_sasa_result_writer.sv
// Scoreboard bench for sasa_result_writer: expected writes are queued as
// words are driven and compared when the sink accepts them.
module tb_sasa_result_writer;

    localparam int unsigned FifoDepth = 8;
    localparam int unsigned SegLen    = 4;
    localparam int unsigned RowStride = 16;
    localparam int unsigned AddrW     = 16;
    localparam int unsigned BaseAddr  = 0;

    typedef struct {
        logic [15:0] addr;
        logic [31:0] data;
    } sb_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        soft_fac = 1'b0;
    logic [31:0] Result = '0;
    logic        finish = 1'b0;
    logic        wr_valid;
    logic        wr_ready = 1'b0;
    logic [15:0] wr_addr;
    logic [31:0] wr_data;
    logic        wb_busy, wb_done, overflow, clamp_flag;
    logic [15:0] wb_count;

    int n_checks = 0;
    int n_fail = 0;
    int delivered = 0;
    int sb_idx = 0;
    sb_t sb_q[$];

    always #5 clk = ~clk;

    sasa_result_writer #(
        .FIFO_DEPTH (FifoDepth),
        .SEG_LEN    (SegLen),
        .ROW_STRIDE (RowStride),
        .ADDR_W     (AddrW),
        .BASE_ADDR  (BaseAddr)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .soft_fac   (soft_fac),
        .Result     (Result),
        .finish     (finish),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wb_busy    (wb_busy),
        .wb_done    (wb_done),
        .overflow   (overflow),
        .clamp_flag (clamp_flag),
        .wb_count   (wb_count)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(input logic [31:0] d);
`ifdef SASA_WB_CLAMP_EN
        return d[31] ? 32'h0 : d;
`else
        return d;
`endif
    endfunction

    // Expected write address of the idx-th word since the last COLLECT entry.
    function automatic logic [15:0] exp_addr(input int idx);
        int a;
        a = BaseAddr + (idx / SegLen) * RowStride + (idx % SegLen);
        return 16'(a);
    endfunction

    // Words fit while the FIFO plus output register have room; wr_ready is
    // held low whenever that limit can be reached.
    task automatic drive_word(input logic [31:0] d, input logic fin);
        sb_t e;
        soft_fac = 1'b1;
        Result   = d;
        finish   = fin;
        if (sb_q.size() < FifoDepth + 1) begin
            e.addr = exp_addr(sb_idx);
            e.data = exp_word(d);
            sb_q.push_back(e);
            sb_idx++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        soft_fac = 1'b0;
        finish   = 1'b0;
        Result   = '0;
    endtask

    task automatic wait_done(input string tag);
        @(negedge clk);
        for (int i = 0; i < 200; i++) begin
            if (wb_done) break;
            @(negedge clk);
        end
        check_eq(tag, {31'b0, wb_done}, 32'd1);
    endtask

    // Sink side: compare each accepted write against the scoreboard head.
    always @(negedge clk) begin
        if (reset && wr_valid && wr_ready) begin
            if (sb_q.size() == 0) begin
                check_eq("unexpected_write", 32'd1, 32'd0);
            end else begin
                sb_t e;
                e = sb_q.pop_front();
                check_eq("wr_addr", {16'b0, wr_addr}, {16'b0, e.addr});
                check_eq("wr_data", wr_data, e.data);
            end
            delivered++;
        end
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check_eq("rst_wr_valid", {31'b0, wr_valid}, 32'd0);
        check_eq("rst_wr_addr", {16'b0, wr_addr}, 32'd0);
        check_eq("rst_wr_data", wr_data, 32'd0);
        check_eq("rst_busy", {31'b0, wb_busy}, 32'd0);
        check_eq("rst_done", {31'b0, wb_done}, 32'd0);
        check_eq("rst_count", {16'b0, wb_count}, 32'd0);
        check_eq("rst_ovf", {31'b0, overflow}, 32'd0);
        check_eq("rst_clamp", {31'b0, clamp_flag}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Burst: 8 words with the sink always ready
        wr_ready  = 1'b1;
        sb_idx    = 0;
        delivered = 0;
        for (int i = 1; i <= 8; i++) drive_word(32'(i), 1'b0);
        soft_fac = 1'b0;
        finish   = 1'b1;
        @(posedge clk);
        #1;
        idle_inputs();
        wait_done("burst_done");
        check_eq("burst_delivered", 32'(delivered), 32'd8);
        check_eq("burst_count", {16'b0, wb_count}, 32'd8);
        check_eq("burst_sb_empty", 32'(sb_q.size()), 32'd0);

        // Backpressure: first word must hold while the sink stalls
        @(posedge clk);
        #1;
        wr_ready  = 1'b0;
        sb_idx    = 0;
        delivered = 0;
        for (int i = 0; i < 3; i++) drive_word(32'h100 + 32'(i), 1'b0);
        idle_inputs();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("bp_valid", {31'b0, wr_valid}, 32'd1);
            check_eq("bp_hold_data", wr_data, 32'h100);
            check_eq("bp_hold_addr", {16'b0, wr_addr}, 32'd0);
        end
        @(posedge clk);
        #1;
        wr_ready = 1'b1;
        wait_done("bp_done");
        check_eq("bp_delivered", 32'(delivered), 32'd3);
        check_eq("bp_count", {16'b0, wb_count}, 32'd3);
        check_eq("bp_ovf", {31'b0, overflow}, 32'd0);

        // Overflow: 10 words into depth 8 plus the output register
        @(posedge clk);
        #1;
        wr_ready  = 1'b0;
        sb_idx    = 0;
        delivered = 0;
        for (int i = 0; i < 10; i++) drive_word(32'h200 + 32'(i), 1'b0);
        idle_inputs();
        @(negedge clk);
        check_eq("ovf_flag", {31'b0, overflow}, 32'd1);
        check_eq("ovf_sb_size", 32'(sb_q.size()), 32'd9);
        @(posedge clk);
        #1;
        wr_ready = 1'b1;
        wait_done("ovf_done");
        check_eq("ovf_delivered", 32'(delivered), 32'd9);
        check_eq("ovf_count", {16'b0, wb_count}, 32'd9);

        // Clamp: negative word
        @(posedge clk);
        #1;
        sb_idx    = 0;
        delivered = 0;
        drive_word(32'hFFFF_FFF0, 1'b0);
        idle_inputs();
        wait_done("clamp_done");
        check_eq("clamp_delivered", 32'(delivered), 32'd1);
`ifdef SASA_WB_CLAMP_EN
        check_eq("clamp_flag", {31'b0, clamp_flag}, 32'd1);
`else
        check_eq("clamp_flag", {31'b0, clamp_flag}, 32'd0);
`endif
        check_eq("clamp_ovf_cleared", {31'b0, overflow}, 32'd0);

        // Reset mid-DRAIN with 4 words buffered
        @(posedge clk);
        #1;
        wr_ready = 1'b0;
        sb_idx   = 0;
        for (int i = 0; i < 4; i++) drive_word(32'h300 + 32'(i), 1'b0);
        idle_inputs();
        @(posedge clk);
        #1;
        check_eq("mid_busy", {31'b0, wb_busy}, 32'd1);
        reset = 1'b0;
        sb_q.delete();
        @(posedge clk);
        #1;
        @(negedge clk);
        check_eq("mrst_valid", {31'b0, wr_valid}, 32'd0);
        check_eq("mrst_busy", {31'b0, wb_busy}, 32'd0);
        check_eq("mrst_count", {16'b0, wb_count}, 32'd0);
        @(posedge clk);
        #1;
        reset     = 1'b1;
        wr_ready  = 1'b1;
        sb_idx    = 0;
        delivered = 0;
        for (int i = 0; i < 3; i++) drive_word(32'h400 + 32'(i), 1'b0);
        idle_inputs();
        wait_done("mrst_done");
        check_eq("mrst_delivered", 32'(delivered), 32'd3);
        check_eq("mrst_new_count", {16'b0, wb_count}, 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
